// File: rtl/filter_window_ctrl.sv
// filter_window_ctrl: frame-position tracker and address sequencer for a 3x3 filter's circular 3-row line buffer
module filter_window_ctrl #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_ready,
    input  logic              frame_start,
    input  logic              enable,
    output logic              buf_we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr_top,
    output logic [ADDR_W-1:0] raddr_mid,
    output logic [ADDR_W-1:0] raddr_bot,
    output logic [11:0]       col,
    output logic [10:0]       row,
    output logic              window_valid,
    output logic              line_done,
    output logic              frame_done,
    output logic [1:0]        state
);
    localparam int DEPTH = 3 * WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

    state_t            state_q;
    logic [11:0]       col_q;
    logic [10:0]       row_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              accept;
    logic [11:0]       pcol;
    logic [10:0]       prow;
    logic [ADDR_W-1:0] pptr;
    logic              last_col;
    logic              last_pix;

    // Subtraction on the circular buffer: wraps at DEPTH, not at 2^ADDR_W
    function automatic logic [ADDR_W-1:0] sub_mod(input logic [ADDR_W-1:0] a, input int d);
        int t;
        t = int'(a) + DEPTH - d;
        return ADDR_W'(t >= DEPTH ? t - DEPTH : t);
    endfunction

    // Position of the pixel being accepted this cycle; frame_start forces it to (0,0)
    always_comb begin
        accept   = video_ready && (frame_start || state_q != IDLE);
        pcol     = frame_start ? '0 : col_q;
        prow     = frame_start ? '0 : row_q;
        pptr     = frame_start ? '0 : ptr_q;
        last_col = pcol == 12'(WIDTH - 1);
        last_pix = last_col && prow == 11'(HEIGHT - 1);
    end

    // Frame FSM, position counters and registered buffer-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            ptr_q        <= '0;
            buf_we       <= 1'b0;
            waddr        <= '0;
            raddr_top    <= '0;
            raddr_mid    <= '0;
            raddr_bot    <= '0;
            col          <= '0;
            row          <= '0;
            window_valid <= 1'b0;
            line_done    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            buf_we       <= accept;
            window_valid <= accept && enable && prow >= 11'd2 && pcol >= 12'd2;
            line_done    <= accept && last_col;
            frame_done   <= accept && last_pix;
            if (accept) begin
                waddr     <= pptr;
                raddr_bot <= sub_mod(pptr, 2);
                raddr_mid <= sub_mod(pptr, 2 + WIDTH);
                raddr_top <= sub_mod(pptr, 2 + 2 * WIDTH);
                col       <= pcol;
                row       <= prow;
                col_q     <= last_pix || last_col ? '0 : pcol + 12'd1;
                row_q     <= last_pix ? '0 : last_col ? prow + 11'd1 : prow;
                ptr_q     <= last_pix || pptr == ADDR_W'(DEPTH - 1) ? '0 : pptr + ADDR_W'(1);
                state_q   <= last_pix ? IDLE :
                             pcol == 12'd2 && prow == 11'd2 ? RUN :
                             frame_start ? PRIME : state_q;
            end else if (frame_start) begin
                col_q   <= '0;
                row_q   <= '0;
                ptr_q   <= '0;
                state_q <= PRIME;
            end
        end
    end

    assign state = state_q;
endmodule
